// File: rtl/aurora_frame_gen.sv
// rtl/aurora_frame_gen.sv - LFSR-patterned AXI4-Stream frame source for Aurora 64B/66B bring-up
// Frames of FRAME_LEN_BEATS beats separated by GAP_BEATS idle cycles; last-beat byte count rotates 32..1.
module aurora_frame_gen #(
  parameter int          FRAME_LEN_BEATS = 16,
  parameter int          GAP_BEATS       = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hABCD
) (
  input  logic         USER_CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  output logic [0:255] TX_TDATA,
  output logic         TX_TVALID,
  input  logic         TX_TREADY,
  output logic         TX_TLAST,
  output logic [31:0]  TX_TKEEP,
  output logic [31:0]  FRAMES_SENT,
  output logic         BUSY
);

  localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN_BEATS - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);
  localparam bit          ONE_BEAT  = (FRAME_LEN_BEATS == 1);
  localparam bit          HAS_GAP   = (GAP_BEATS > 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] beat_cnt;
  logic [15:0] gap_cnt;
  logic [5:0]  last_bytes;
  logic [5:0]  lb_next;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[4] ^ v[3] ^ v[2]};
  endfunction

  function automatic logic [31:0] keep_for(input logic [5:0] n);
    return ~(32'hFFFFFFFF >> n);
  endfunction

  // Keep value for the first beat of a frame: only a one-beat frame is also its last beat.
  function automatic logic [31:0] start_keep(input logic [5:0] n);
    return ONE_BEAT ? keep_for(n) : 32'hFFFFFFFF;
  endfunction

  assign lb_next  = (last_bytes == 6'd1) ? 6'd32 : last_bytes - 6'd1;
  assign TX_TDATA = {16{lfsr}};

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      last_bytes  <= 6'd32;
      TX_TVALID   <= 1'b0;
      TX_TLAST    <= 1'b0;
      TX_TKEEP    <= 32'hFFFFFFFF;
      FRAMES_SENT <= '0;
      BUSY        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ENABLE) begin
            state     <= SEND;
            TX_TVALID <= 1'b1;
            BUSY      <= 1'b1;
            TX_TLAST  <= ONE_BEAT;
            TX_TKEEP  <= start_keep(last_bytes);
          end
        end
        SEND: begin
          if (TX_TVALID && TX_TREADY) begin
            lfsr <= lfsr_next(lfsr);
            if (beat_cnt == LAST_BEAT) begin
              FRAMES_SENT <= FRAMES_SENT + 32'd1;
              beat_cnt    <= '0;
              last_bytes  <= lb_next;
              if (HAS_GAP) begin
                state     <= GAP;
                TX_TVALID <= 1'b0;
                TX_TLAST  <= 1'b0;
                TX_TKEEP  <= 32'hFFFFFFFF;
              end else if (ENABLE) begin
                TX_TLAST <= ONE_BEAT;
                TX_TKEEP <= start_keep(lb_next);
              end else begin
                state     <= IDLE;
                TX_TVALID <= 1'b0;
                BUSY      <= 1'b0;
                TX_TLAST  <= 1'b0;
                TX_TKEEP  <= 32'hFFFFFFFF;
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
              // Register TLAST/TKEEP one beat early so they present with the final beat.
              if (beat_cnt + 16'd1 == LAST_BEAT) begin
                TX_TLAST <= 1'b1;
                TX_TKEEP <= keep_for(last_bytes);
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (ENABLE) begin
              state     <= SEND;
              TX_TVALID <= 1'b1;
              TX_TLAST  <= ONE_BEAT;
              TX_TKEEP  <= start_keep(last_bytes);
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_frame_gen.sv
// tb/tb_aurora_frame_gen.sv - scoreboard bench for aurora_frame_gen
module tb_aurora_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, rdy;
  logic [0:255] tdata;
  logic         tvalid, tlast, busy;
  logic [31:0]  tkeep, frames;

  logic         rst1, en1, rdy1;
  logic [0:255] tdata1;
  logic         tvalid1, tlast1, busy1;
  logic [31:0]  tkeep1, frames1;

  aurora_frame_gen dut (
    .USER_CLK(clk), .RESET(rst), .ENABLE(en),
    .TX_TDATA(tdata), .TX_TVALID(tvalid), .TX_TREADY(rdy),
    .TX_TLAST(tlast), .TX_TKEEP(tkeep), .FRAMES_SENT(frames), .BUSY(busy)
  );

  aurora_frame_gen #(.FRAME_LEN_BEATS(1), .GAP_BEATS(0)) dut1 (
    .USER_CLK(clk), .RESET(rst1), .ENABLE(en1),
    .TX_TDATA(tdata1), .TX_TVALID(tvalid1), .TX_TREADY(rdy1),
    .TX_TLAST(tlast1), .TX_TKEEP(tkeep1), .FRAMES_SENT(frames1), .BUSY(busy1)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        last;
    logic [31:0] keep;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  beat_t       exp1_q[$];
  logic [15:0] m_lfsr;
  int          m_lb;
  logic [31:0] m_frames;
  logic        mon_en;
  int          acc;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[4] ^ v[3] ^ v[2];
    return {v[14:0], fb};
  endfunction

  function automatic logic [31:0] model_keep(input int n);
    logic [31:0] k;
    k = '0;
    for (int b = 0; b < n; b++) k[31-b] = 1'b1;
    return k;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hABCD;
    m_lb   = 32;
  endtask

  task automatic push_frames(input int n, input int len, input int sel);
    beat_t e;
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < len; b++) begin
        e.d    = m_lfsr;
        e.last = (b == len - 1);
        e.keep = e.last ? model_keep(m_lb) : 32'hFFFFFFFF;
        if (sel == 0) exp_q.push_back(e);
        else exp1_q.push_back(e);
        m_lfsr = model_step(m_lfsr);
        if (e.last) m_lb = (m_lb == 1) ? 32 : m_lb - 1;
      end
    end
  endtask

  task automatic monitor();
    logic         stall = 1'b0;
    logic [0:255] hd = '0;
    logic [0:255] xd;
    logic         hl = 1'b0;
    logic [31:0]  hk = '0;
    beat_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall) begin
          checks++;
          if (tvalid !== 1'b1 || tdata !== hd || tlast !== hl || tkeep !== hk) begin
            errors++;
            $display("FAIL stall_hold: valid=%b last=%b keep=%h word=%h, required valid=1 last=%b keep=%h word=%h",
                     tvalid, tlast, tkeep, tdata[0:15], hl, hk, hd[0:15]);
          end
        end
        stall = tvalid && !rdy;
        hd = tdata; hl = tlast; hk = tkeep;
        if (tvalid && rdy) begin
          acc++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: word=%h last=%b, required no beat", tdata[0:15], tlast);
          end else begin
            e  = exp_q.pop_front();
            xd = {16{e.d}};
            if (tdata !== xd || tlast !== e.last || tkeep !== e.keep) begin
              errors++;
              $display("FAIL beat: word=%h last=%b keep=%h, required word=%h last=%b keep=%h",
                       tdata[0:15], tlast, tkeep, e.d, e.last, e.keep);
            end
          end
        end
      end else begin
        stall = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b1; mon_en = 1'b0;
    repeat (2) step();
    model_reset();
    exp_q.delete();
    acc = 0;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc < target && n < budget) begin step(); n++; end
    checks++;
    if (acc < target) begin
      errors++;
      $display("FAIL wait_acc_timeout: accepted=%0d, required %0d", acc, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [0:255] xd;
    xd = {16{16'hABCD}};
    rst = 1'b1; en = 1'b0; rdy = 1'b0; mon_en = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: %b, required 0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: %b, required 0", tlast); end
    checks++; if (tkeep !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_tkeep: %h, required ffffffff", tkeep); end
    checks++; if (tdata !== xd) begin errors++; $display("FAIL reset_tdata: %h, required %h", tdata[0:15], xd[0:15]); end
    checks++; if (frames !== 32'd0) begin errors++; $display("FAIL reset_frames: %0d, required 0", frames); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
  endtask

  task automatic test_basic();
    logic exp_v;
    do_reset();
    push_frames(2, 16, 0);
    step();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL enable_latency: tvalid=%b, required 0", tvalid); end
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      exp_v = (c < 36) && ((c % 20) < 16);
      checks++;
      if (tvalid !== exp_v) begin errors++; $display("FAIL basic_valid c=%0d: %b, required %b", c, tvalid, exp_v); end
      if (c == 16) begin
        checks++;
        if (frames !== 32'd1) begin errors++; $display("FAIL basic_frames1: %0d, required 1", frames); end
      end
      if (c == 36) begin
        checks++;
        if (frames !== 32'd2) begin errors++; $display("FAIL basic_frames2: %0d, required 2", frames); end
      end
      if (c == 40) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: %b, required 0", busy); end
      end
      if (c == 25) en = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: %0d beats, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    push_frames(2, 16, 0);
    step();
    en = 1'b1;
    while (n < 400 && !(acc > 0 && busy === 1'b0)) begin
      step();
      rdy = 1'($urandom_range(0, 1));
      if (acc >= 20) en = 1'b0;
      n++;
    end
    rdy = 1'b1;
    checks++;
    if (frames !== 32'd2) begin errors++; $display("FAIL bp_frames: %0d, required 2", frames); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: %0d beats, required 0", exp_q.size()); end
  endtask

  task automatic test_enable_drop();
    logic seen = 1'b0;
    do_reset();
    push_frames(1, 16, 0);
    step();
    en = 1'b1;
    wait_acc(5, 100);
    en = 1'b0;
    wait_idle(100);
    checks++;
    if (frames !== 32'd1) begin errors++; $display("FAIL drop_frames: %0d, required 1", frames); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_leftover: %0d beats, required 0", exp_q.size()); end
    repeat (10) begin
      @(negedge clk);
      if (tvalid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL drop_quiet: activity seen=1, required 0"); end
  endtask

  task automatic test_reset_mid();
    push_frames(1, 16, 0);
    step();
    en = 1'b1;
    wait_acc(acc + 7, 100);
    rst = 1'b1;
    mon_en = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: %b, required 0", tvalid); end
    checks++;
    if (frames !== 32'd0) begin errors++; $display("FAIL midrst_frames: %0d, required 0", frames); end
    model_reset();
    exp_q.delete();
    push_frames(1, 16, 0);
    acc = 0;
    mon_en = 1'b1;
    wait_acc(3, 100);
    en = 1'b0;
    wait_idle(100);
    checks++;
    if (frames !== 32'd1) begin errors++; $display("FAIL midrst_after: %0d, required 1", frames); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_leftover: %0d beats, required 0", exp_q.size()); end
  endtask

  task automatic test_single_beat();
    beat_t        e;
    logic [0:255] xd;
    rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b1;
    repeat (2) step();
    rst1 = 1'b0;
    model_reset();
    push_frames(33, 1, 1);
    step();
    en1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      e  = exp1_q.pop_front();
      xd = {16{e.d}};
      checks++;
      if (tvalid1 !== 1'b1 || tlast1 !== 1'b1 || tkeep1 !== e.keep || tdata1 !== xd) begin
        errors++;
        $display("FAIL single_beat %0d: valid=%b last=%b keep=%h word=%h, required valid=1 last=1 keep=%h word=%h",
                 i, tvalid1, tlast1, tkeep1, tdata1[0:15], e.keep, e.d);
      end
      if (i == 32) en1 = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (frames1 !== 32'd33) begin errors++; $display("FAIL single_frames: %0d, required 33", frames1); end
    checks++;
    if (tvalid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL single_stop: valid=%b busy=%b, required 0 0", tvalid1, busy1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.FRAMES_SENT = 32'hFFFFFFFE;
    step();
    release dut.FRAMES_SENT;
    @(negedge clk);
    checks++;
    if (frames !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap_preload: %h, required fffffffe", frames); end
    m_frames = 32'hFFFFFFFE;
    push_frames(2, 16, 0);
    step();
    en = 1'b1;
    wait_acc(20, 200);
    en = 1'b0;
    wait_idle(200);
    m_frames = m_frames + 32'd2;
    checks++;
    if (frames !== m_frames) begin errors++; $display("FAIL wrap_count: %h, required %h", frames, m_frames); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: %0d beats, required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b1; mon_en = 1'b0; acc = 0;
    rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b1;
    m_frames = '0;
    model_reset();
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_single_beat();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_frame_gen.md
Name: aurora_frame_gen

Overview:
- Upstream traffic source for the 4-lane Aurora 64B/66B streaming core.
- Drives the core's 256-bit AXI4-Stream TX interface (tx_tdata/tx_tvalid/tx_tready/tx_tlast/tx_tkeep) with LFSR-patterned frames of programmable length, rotating the last-beat byte count.
- Runs on the core's user clock and is held in reset by the example-level reset2FrameGen (system reset OR channel down).
- Used for link bring-up and loopback BER soak together with the downstream frame checker.

Parameters:
- FRAME_LEN_BEATS, 16, beats per frame including the TLAST beat; legal range 1..65535.
- GAP_BEATS, 4, idle cycles between frames with TVALID low; 0 = back-to-back frames.
- LFSR_SEED, 16'hABCD, LFSR value after reset; must be nonzero.

Ports:
- USER_CLK, input, 1, core user clock; all logic is on its rising edge.
- RESET, input, 1, synchronous active-high reset, driven from reset2FrameGen.
- ENABLE, input, 1, traffic enable; sampled only at frame boundaries.
- TX_TDATA, output, [0:255], frame data; byte i is TX_TDATA[8i:8i+7].
- TX_TVALID, output, 1, AXI4-Stream valid.
- TX_TREADY, input, 1, AXI4-Stream ready from the core.
- TX_TLAST, output, 1, marks the final beat of a frame.
- TX_TKEEP, output, [31:0], byte enables; bit 31-i qualifies byte i.
- FRAMES_SENT, output, [31:0], count of completed frames (last beat accepted); wraps.
- BUSY, output, 1, high while the FSM is in SEND or GAP.

Behaviour:
- Beat acceptance is defined as TX_TVALID & TX_TREADY on a USER_CLK rising edge.
- Reset (RESET=1 at a clock edge):
  - Outputs: TX_TVALID=0, TX_TLAST=0, TX_TKEEP=32'hFFFFFFFF, TX_TDATA={16{LFSR_SEED}}, FRAMES_SENT=0, BUSY=0.
  - State: FSM goes to IDLE, lfsr=LFSR_SEED, beat_cnt=0, gap_cnt=0, last_bytes=32.
  - Reset mid-frame drops TVALID on the next edge. No TLAST is emitted for the truncated frame.
- FSM states:
  - IDLE: TVALID=0. If ENABLE=1, go to SEND and assert TVALID on the next cycle (1-cycle latency from ENABLE to TVALID).
  - SEND: TVALID=1. On each accepted beat, advance lfsr and increment beat_cnt.
    - On the accepted beat with beat_cnt==FRAME_LEN_BEATS-1:
      - increment FRAMES_SENT;
      - beat_cnt←0;
      - last_bytes←(last_bytes==1)?32:last_bytes-1;
      - next state is GAP if GAP_BEATS>0, else SEND if ENABLE=1, else IDLE.
  - GAP: TVALID=0, gap_cnt counts up. At gap_cnt==GAP_BEATS-1, go to SEND if ENABLE=1, else IDLE; clear gap_cnt.
- AXI4-Stream rules:
  - Once TVALID is high, TDATA/TLAST/TKEEP/TVALID hold stable until the beat is accepted.
  - TVALID never depends combinationally on TREADY. All outputs are registered.
  - TREADY low stalls with no state change, for any duration.
- ENABLE deassertion mid-frame does not truncate the frame. The frame completes and then the FSM stops at the boundary.
- Data pattern:
  - LFSR polynomial x^16+x^5+x^4+x^3+1, Fibonacci form, shift left, feedback into bit 0.
  - TX_TDATA = {16{lfsr}}.
  - The LFSR advances once per accepted beat only; it does not advance on stall or gap cycles.
  - The LFSR is not reset between frames.
- TLAST/TKEEP:
  - TX_TLAST=1 only on beat FRAME_LEN_BEATS-1.
  - Non-last beats: TX_TKEEP=32'hFFFFFFFF.
  - Last beat: TX_TKEEP = ~(32'hFFFFFFFF >> last_bytes), i.e. the top last_bytes bits are set. last_bytes=32 gives all ones; last_bytes=1 gives 32'h80000000.
  - Sequence per frame starts 32,31,…,1 and then wraps to 32.
- FRAME_LEN_BEATS=1: every beat carries TLAST. The last_bytes rotation applies per beat.
- FRAMES_SENT wraps from 32'hFFFFFFFF to 0 with no flag.
- BUSY=1 in SEND and GAP, 0 in IDLE.

Test Plan:
1. Reset → ENABLE=1, TREADY=1, defaults: TVALID rises 1 cycle after ENABLE. Frame 0 is 16 beats, TLAST on beat 15 with TKEEP=FFFFFFFF. Then 4 TVALID-low cycles. Frame 1 last TKEEP=FFFFFFFE. FRAMES_SENT=1 then 2.
2. TREADY toggled by random 50% pattern → TDATA/TKEEP/TLAST are stable across every stall. Accepted-beat data sequence is identical to scenario 1: first beat ABCDABCD…, second = {16{lfsr_next(ABCD)}}.
3. ENABLE dropped on beat 5 of a frame → remaining 10 beats still sent with TLAST. FSM passes through GAP to IDLE. BUSY=0 afterwards. No further TVALID.
4. RESET asserted on beat 7 with TREADY=1 → TVALID=0 the next cycle and FRAMES_SENT=0. After release and ENABLE, the first beat data = {16{ABCD}} and the next TLAST is on the 16th beat.
5. FRAME_LEN_BEATS=1, GAP_BEATS=0, TREADY=1 for 33 cycles → every beat has TLAST. TKEEP sequence is FFFFFFFF, FFFFFFFE, …, 80000000, FFFFFFFF. FRAMES_SENT=33.
6. Force FRAMES_SENT near wrap (run with preloaded count via bind/force of 32'hFFFFFFFE) → two frames later it reads 0 and no other behaviour changes.
